// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_unit_if
//  Purpose  : Request/response bundle between the execute stage and the
//             multi-cycle multiply/divide engine.
//  Revision : 1.0  initial release
// ============================================================================
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Pipeline side: issues requests and watches the handshake.
    modport master (
        output start, op, op_a, op_b,
        input  busy, done, hi, lo
    );

    // Engine side.
    modport slave (
        input  start, op, op_a, op_b,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_unit
//  Purpose  : Bit-serial MULT/MULTU/DIV/DIVU engine producing a {hi, lo}
//             result. Shift-add multiply, restoring divide, one bit/cycle.
//  Revision : 1.0  initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic      clk,
    input  wire logic      reset,
    mult_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [1:0]       op_q,      op_d;
    logic [WIDTH-1:0] a_q,       a_d;      // raw dividend / multiplicand
    logic [WIDTH-1:0] b_q,       b_d;      // raw divisor / multiplier
    logic [WIDTH-1:0] acc_q,     acc_d;    // upper accumulator / remainder
    logic [WIDTH-1:0] mq_q,      mq_d;     // multiplier / quotient
    logic [WIDTH-1:0] mcand_q,   mcand_d;  // multiplicand / divisor magnitude
    logic [WIDTH-1:0] hi_q,      hi_d;
    logic [WIDTH-1:0] lo_q,      lo_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;

    logic             w_is_div;
    logic             w_is_signed;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_rem_diff;
    logic [2*WIDTH-1:0] w_prod_fix;

    // Arithmetic for one iteration plus the magnitude and sign-fix terms.
    // Magnitudes are taken in a dedicated LOAD cycle so the start-side
    // input path is only a register capture.
    always_comb begin
        w_is_div    = op_q[1];
        w_is_signed = ~op_q[0];
        w_a_mag     = (w_is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
        w_b_mag     = (w_is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
        // Carry out of the add is kept and shifted into the accumulator MSB.
        w_mul_sum   = {1'b0, acc_q} + ({1'b0, mcand_q} & {(WIDTH+1){mq_q[0]}});
        w_rem_sh    = {acc_q, mq_q[WIDTH-1]};
        // Bit WIDTH of the difference is the borrow (remainder < divisor).
        w_rem_diff  = w_rem_sh - {1'b0, mcand_q};
        w_prod_fix  = neg_res_q ? -{acc_q, mq_q} : {acc_q, mq_q};
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    op_d    = bus.op;
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                acc_d     = '0;
                cnt_d     = '0;
                mq_d      = w_is_div ? w_a_mag : w_b_mag;
                mcand_d   = w_is_div ? w_b_mag : w_a_mag;
                neg_res_d = w_is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                neg_rem_d = w_is_signed & a_q[WIDTH-1];
                state_d   = S_CALC;
            end
            S_CALC: begin
                if (w_is_div) begin
                    if (!w_rem_diff[WIDTH]) begin
                        acc_d = w_rem_diff[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = w_rem_sh[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = w_mul_sum[WIDTH:1];
                    mq_d  = {w_mul_sum[0], mq_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!w_is_div) begin
                    hi_d = w_prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = w_prod_fix[WIDTH-1:0];
                end else if (b_q == '0) begin
                    // Divide by zero: all-ones quotient, raw dividend as remainder.
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    lo_d = neg_res_q ? -mq_q  : mq_q;
                    hi_d = neg_rem_q ? -acc_q : acc_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign bus.busy = (state_q == S_LOAD) || (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.done = (state_q == S_DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_div_unit
//  Purpose  : Self-checking bench for mult_div_unit against an arithmetic
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(32)) bus();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Result defined by MIPS arithmetic rules; returns {hi, lo}.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint     sa, sb, q, m;
        logic [63:0] ua, ub, uq, um, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        case (o)
            2'b00: r = 64'(sa * sb);
            2'b01: r = ua * ub;
            2'b10: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    uq = ua / ub;
                    um = ua % ub;
                    r  = {um[31:0], uq[31:0]};
                end
            end
        endcase
        return r;
    endfunction

    // Issue one operation, optionally pulse a second start mid-flight, and
    // check latency, busy behaviour and the result.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input int inject);
        logic [63:0] exp;
        int          lat;
        bit          busy_ok;
        logic        busy_at_done;
        exp          = ref_model(o, a, b);
        lat          = 0;
        busy_ok      = 1'b1;
        busy_at_done = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.op_a  = a;
        bus.op_b  = b;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (inject != 0 && k == inject) begin
                bus.start = 1'b1;
                bus.op    = 2'b11;
                bus.op_a  = 32'd9;
                bus.op_b  = 32'd4;
            end
            if (inject != 0 && k == inject + 1) bus.start = 1'b0;
            if (bus.done) begin
                lat          = k;
                busy_at_done = bus.busy;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
        end
        check({tag, " latency"}, 64'(lat), 64'd35);
        check({tag, " busy_held"}, 64'(busy_ok), 64'd1);
        check({tag, " busy_in_done"}, 64'(busy_at_done), 64'd0);
        check({tag, " hi"}, 64'(bus.hi), 64'(exp[63:32]));
        check({tag, " lo"}, 64'(bus.lo), 64'(exp[31:0]));
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;

        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.op_a  = 32'd0;
        bus.op_b  = 32'd0;
        #1;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset hi",   64'(bus.hi),   64'd0);
        check("reset lo",   64'(bus.lo),   64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Directed cases, issued back to back.
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5,         "mult_neg3x5", 0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minmin", 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         "div_neg7d2", 0);
        run_op(2'b11, 32'd100,       32'd7,         "divu_100d7", 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_dm1", 0);
        run_op(2'b11, 32'd1234,      32'd0,         "divu_by0", 0);
        run_op(2'b10, 32'hFFFF_FB2E, 32'd0,         "div_neg_by0", 0);
        run_op(2'b01, 32'd2,         32'd3,         "multu_ignore_start", 10);

        // Random operations.
        for (int i = 0; i < 12; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if (i % 4 == 1) r_b = -r_b;
            run_op(r_op, r_a, r_b, "random", 0);
        end

        // Leave nonzero hi/lo, then abort a divide with reset mid-operation.
        run_op(2'b11, 32'd100, 32'd7, "divu_pre_reset", 0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.op_a  = 32'd1000;
        bus.op_b  = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort done", 64'(bus.done), 64'd0);
        check("abort hi",   64'(bus.hi),   64'd0);
        check("abort lo",   64'(bus.lo),   64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op(2'b01, 32'd4, 32'd4, "multu_after_reset", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
